// File: rtl/muldiv_sequencer_if.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer_if
// Handshake/data bundle between decode and the multiply/divide sequencer.
//   start, op[1:0]        : issue a MULT/MULTU/DIV/DIVU this cycle
//   rs_data, rt_data      : forwarded operands (captured at the start edge)
//   mthi, mtlo, mt_data   : HI/LO writes from MTHI/MTLO
//   read_req              : decode holds an MFHI/MFLO
//   busy, stall           : operation in flight / hold decode and upstream
//   hi, lo                : architectural HI/LO registers
//   done, div_by_zero     : one-cycle completion pulse and its divide-by-0 flag
// master = decode side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface muldiv_sequencer_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        mthi;
   logic        mtlo;
   logic [31:0] mt_data;
   logic        read_req;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        done;
   logic        div_by_zero;

   modport master (
      output start, op, rs_data, rt_data, mthi, mtlo, mt_data, read_req,
      input  busy, stall, hi, lo, done, div_by_zero
   );

   modport slave (
      input  start, op, rs_data, rt_data, mthi, mtlo, mt_data, read_req,
      output busy, stall, hi, lo, done, div_by_zero
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
// Iterative multiply/divide unit and HI/LO owner for the 5-stage MIPS core.
// A shift-add multiplier (MUL_BITS_PER_CYCLE bits per cycle) and a restoring
// divider (1 quotient bit per cycle) are sequenced IDLE -> PREP -> RUN -> FIX.
//
// Ports:
//   clk   : core clock
//   rst   : synchronous active-high reset (abandons any operation in flight)
//   bus   : muldiv_sequencer_if.slave (start/op/operands, mthi/mtlo/mt_data,
//           read_req in; busy/stall/hi/lo/done/div_by_zero out)
//
// Optional feature, macro MULDIV_EARLY_OUT_EN:
//   defined   -> a multiply RUN ends once the remaining multiplier bits are 0
//   undefined -> every multiply RUN lasts 32/MUL_BITS_PER_CYCLE cycles
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
   parameter int MUL_BITS_PER_CYCLE = 1,
   parameter int DIV_CYCLES         = 32
) (
   input  logic              clk,
   input  logic              rst,
   muldiv_sequencer_if.slave bus
);
   localparam int CW = 6;
   localparam int MUL_CYCLES = 32 / MUL_BITS_PER_CYCLE;
   localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;
   state_t state, state_n;

   logic [1:0]    op_q;
   logic [31:0]   rs_q, rt_q;
   logic          neg_main;   // product / quotient sign
   logic          neg_rem;    // remainder follows the dividend
   logic          dvz;
   logic [63:0]   acc, mcand;
   logic [31:0]   mplier;
   logic [31:0]   rem, quo, dvsr;
   logic [CW-1:0] cnt;
   logic [31:0]   hi_q, lo_q;
   logic          done_q, dbz_q;

   logic          is_div, is_signed;
   logic [63:0]   acc_step;
   logic [31:0]   mplier_rest;
   logic [32:0]   trial, trial_sub;
   logic          fits;
   logic [31:0]   rem_step;
   logic          run_last;
   logic [31:0]   res_hi, res_lo;
   logic [63:0]   prod;

   assign is_div    = op_q[1];
   assign is_signed = ~op_q[0];

   function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic sgn);
      return (sgn && v[31]) ? 32'(-v) : 32'(v);
   endfunction

   function automatic logic [31:0] apply_sign32(input logic [31:0] m, input logic neg);
      return neg ? (~m + 32'd1) : m;
   endfunction

   function automatic logic [63:0] apply_sign64(input logic [63:0] m, input logic neg);
      return neg ? (~m + 64'd1) : m;
   endfunction

   // One multiply step: add the shifted multiplicand for every set multiplier bit.
   always_comb begin
      acc_step = acc;
      for (int k = 0; k < MUL_BITS_PER_CYCLE; k++) begin
         if (mplier[k]) acc_step = acc_step + (mcand << k);
      end
   end
   assign mplier_rest = mplier >> MUL_BITS_PER_CYCLE;

   // One restoring divide step on the magnitudes.
   assign trial     = {rem, quo[31]};
   assign fits      = (trial >= {1'b0, dvsr});
   assign trial_sub = trial - {1'b0, dvsr};
   assign rem_step  = fits ? trial_sub[31:0] : trial[31:0];

   always_comb begin
      run_last = is_div ? (cnt == DIV_LAST) : (cnt == MUL_LAST);
`ifdef MULDIV_EARLY_OUT_EN
      if (!is_div && (mplier_rest == '0)) run_last = 1'b1;
`endif
   end

   // FSM: state register and next-state logic.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  if (bus.start) state_n = S_PREP;
         S_PREP:  state_n = S_RUN;
         S_RUN:   if (run_last) state_n = S_FIX;
         S_FIX:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Datapath registers carry no reset; control decides when they matter.
   always_ff @(posedge clk) begin
      case (state)
         // capture: operands frozen at the start edge
         S_IDLE: begin
            if (bus.start) begin
               op_q <= bus.op;
               rs_q <= bus.rs_data;
               rt_q <= bus.rt_data;
            end
         end
         // PREP: magnitudes and result signs
         S_PREP: begin
            mcand    <= {32'd0, mag32(rs_q, is_signed)};
            mplier   <= mag32(rt_q, is_signed);
            acc      <= '0;
            quo      <= mag32(rs_q, is_signed);
            dvsr     <= mag32(rt_q, is_signed);
            rem      <= '0;
            neg_main <= is_signed & (rs_q[31] ^ rt_q[31]);
            neg_rem  <= is_signed & rs_q[31];
            dvz      <= (rt_q == '0);
            cnt      <= '0;
         end
         // RUN: iterate
         S_RUN: begin
            cnt <= cnt + 6'd1;
            if (is_div) begin
               rem <= rem_step;
               quo <= {quo[30:0], fits};
            end else begin
               acc    <= acc_step;
               mcand  <= mcand << MUL_BITS_PER_CYCLE;
               mplier <= mplier_rest;
            end
         end
         default: ;
      endcase
   end

   // FIX: signed result, divide-by-zero override
   assign prod = apply_sign64(acc, neg_main);

   always_comb begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
      if (is_div) begin
         if (dvz) begin
            res_hi = rs_q;
            res_lo = 32'hFFFF_FFFF;
         end else begin
            res_hi = apply_sign32(rem, neg_rem);
            res_lo = apply_sign32(quo, neg_main);
         end
      end
   end

   // HI/LO and completion pulses. An IDLE start takes priority over mthi/mtlo.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         done_q <= (state == S_FIX);
         dbz_q  <= (state == S_FIX) & is_div & dvz;
         if (state == S_FIX) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
         end else if ((state == S_IDLE) && !bus.start) begin
            if (bus.mthi) hi_q <= bus.mt_data;
            if (bus.mtlo) lo_q <= bus.mt_data;
         end
      end
   end

   assign bus.busy        = (state != S_IDLE);
   assign bus.stall       = bus.busy & (bus.start | bus.read_req | bus.mthi | bus.mtlo);
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
   localparam int MBPC = 1;
`ifdef MULDIV_EARLY_OUT_EN
   localparam int LAT_M3X7  = 6;
   localparam int LAT_M9X5  = 6;
   localparam int LAT_K4    = 4;
`else
   localparam int LAT_M3X7  = 35;
   localparam int LAT_M9X5  = 35;
   localparam int LAT_K4    = 11;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   muldiv_sequencer_if bus();
   muldiv_sequencer_if bus4();

   muldiv_sequencer #(.MUL_BITS_PER_CYCLE(MBPC), .DIV_CYCLES(32)) u_dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   muldiv_sequencer #(.MUL_BITS_PER_CYCLE(4), .DIV_CYCLES(32)) u_dut4 (
      .clk(clk), .rst(rst), .bus(bus4)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [64:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (op == 2'b00) return {1'b0, 64'(sa * sb)};
      if (op == 2'b01) return {1'b0, {32'd0, a} * {32'd0, b}};
      if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
      if (op == 2'b10) begin
         q = sa / sb;
         r = sa % sb;
      end else begin
         q = longint'({32'd0, a}) / longint'({32'd0, b});
         r = longint'({32'd0, a}) % longint'({32'd0, b});
      end
      p = {r[31:0], q[31:0]};
      return {1'b0, p};
   endfunction

   function automatic int model_lat(input logic [1:0] op, input logic [31:0] b);
      if (op[1]) return 35;
`ifdef MULDIV_EARLY_OUT_EN
      begin
         logic [31:0] m;
         int bits;
         m = (op == 2'b00 && b[31]) ? -b : b;
         bits = 1;
         for (int i = 0; i < 32; i++) if (m[i]) bits = i + 1;
         return 3 + (bits + MBPC - 1) / MBPC;
      end
`else
      return 3 + 32 / MBPC;
`endif
   endfunction

   bit          m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
   logic [31:0] m_hi = '0, m_lo = '0;
   int          m_rem = 0;
   logic [64:0] m_res = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
         m_hi <= '0; m_lo <= '0;
      end else begin
         m_done <= 1'b0;
         m_dbz  <= 1'b0;
         if (m_busy) begin
            if (m_rem == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_dbz  <= m_res[64];
               m_hi   <= m_res[63:32];
               m_lo   <= m_res[31:0];
            end
            m_rem <= m_rem - 1;
         end else if (bus.start) begin
            m_busy <= 1'b1;
            m_rem  <= model_lat(bus.op, bus.rt_data) - 1;
            m_res  <= model_result(bus.op, bus.rs_data, bus.rt_data);
         end else begin
            if (bus.mthi) m_hi <= bus.mt_data;
            if (bus.mtlo) m_lo <= bus.mt_data;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy",  64'(bus.busy),  64'(m_busy));
         chk("stall", 64'(bus.stall),
             64'(m_busy & (bus.start | bus.read_req | bus.mthi | bus.mtlo)));
         chk("hi",    64'(bus.hi),    64'(m_hi));
         chk("lo",    64'(bus.lo),    64'(m_lo));
         chk("done",  64'(bus.done),  64'(m_done));
         chk("dbz",   64'(bus.div_by_zero), 64'(m_dbz));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1; bus.op = op; bus.rs_data = a; bus.rt_data = b;
      step();
      bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
      bus.rs_data = '1; bus.rt_data = '1;
   endtask

   // Entered in cycle 1; returns at the negedge of the done cycle.
   task automatic wait_done(output int cyc, output int nbusy, output logic dbz);
      cyc = 1; nbusy = 0; dbz = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.done) begin
            dbz = bus.div_by_zero;
            break;
         end
         if (bus.busy) nbusy++;
         if (cyc >= 200) break;
         @(posedge clk); #1; cyc++;
      end
   endtask

   task automatic run_check(input string nm, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int exp_cyc, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo, input logic exp_dbz);
      int cyc, nb;
      logic dz;
      issue(op, a, b);
      wait_done(cyc, nb, dz);
      chk({nm, "_cycle"}, 64'(cyc), 64'(exp_cyc));
      chk({nm, "_hi"}, 64'(bus.hi), 64'(exp_hi));
      chk({nm, "_lo"}, 64'(bus.lo), 64'(exp_lo));
      chk({nm, "_dbz"}, 64'(dz), 64'(exp_dbz));
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, nb, ndone;
      logic dz;
      bus.start = 0; bus.op = 0; bus.rs_data = 0; bus.rt_data = 0;
      bus.mthi = 0; bus.mtlo = 0; bus.mt_data = 0; bus.read_req = 0;
      bus4.start = 0; bus4.op = 0; bus4.rs_data = 0; bus4.rt_data = 0;
      bus4.mthi = 0; bus4.mtlo = 0; bus4.mt_data = 0; bus4.read_req = 0;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset_hi",   64'(bus.hi), 64'd0);
      chk("reset_lo",   64'(bus.lo), 64'd0);
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_done", 64'(bus.done), 64'd0);
      step();

      // 4 bits/cycle instance: MULT -3 * 7
      bus4.start = 1'b1; bus4.op = 2'b00; bus4.rs_data = 32'hFFFF_FFFD; bus4.rt_data = 32'd7;
      step();
      bus4.start = 1'b0;
      cyc = 1;
      while (cyc < 100) begin
         @(negedge clk);
         if (bus4.done) break;
         @(posedge clk); #1; cyc++;
      end
      chk("k4_cycle", 64'(cyc), 64'(LAT_K4));
      chk("k4_hi", 64'(bus4.hi), 64'h0000_0000_FFFF_FFFF);
      chk("k4_lo", 64'(bus4.lo), 64'h0000_0000_FFFF_FFEB);
      step();

      // MULTU max * max with busy length
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(cyc, nb, dz);
      chk("multu_max_cycle", 64'(cyc), 64'd35);
      chk("multu_max_busy_cycles", 64'(nb), 64'd34);
      chk("multu_max_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
      chk("multu_max_lo", 64'(bus.lo), 64'h0000_0000_0000_0001);
      step();

      run_check("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, LAT_M3X7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      run_check("multu_9x5", 2'b01, 32'd9, 32'd5, LAT_M9X5, 32'd0, 32'd45, 1'b0);
      run_check("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 35, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_check("divu_7_0", 2'b11, 32'd7, 32'd0, 35, 32'd7, 32'hFFFF_FFFF, 1'b1);
      run_check("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 35, 32'd0, 32'h8000_0000, 1'b0);

      // read_req held from cycle 5, competing start at cycle 10
      issue(2'b01, 32'h8000_0000, 32'h8000_0003);
      for (int c = 1; c <= 36; c++) begin
         bus.read_req = (c >= 5 && c <= 35);
         bus.start    = (c == 10);
         if (c == 10) begin bus.op = 2'b01; bus.rs_data = 32'd2; bus.rt_data = 32'd3; end
         @(negedge clk);
         if (c == 4)  chk("stall_c4", 64'(bus.stall), 64'd0);
         if (c == 5)  chk("stall_c5", 64'(bus.stall), 64'd1);
         if (c == 10) chk("stall_c10", 64'(bus.stall), 64'd1);
         if (c == 34) chk("stall_c34", 64'(bus.stall), 64'd1);
         if (c == 35) begin
            chk("stall_c35", 64'(bus.stall), 64'd0);
            chk("stall_done_c35", 64'(bus.done), 64'd1);
            chk("stall_lo_c35", 64'(bus.lo), 64'h0000_0000_8000_0000);
         end
         @(posedge clk); #1;
      end
      bus.read_req = 1'b0; bus.start = 1'b0;
      repeat (3) step();
      @(negedge clk);
      chk("ignored_start_busy", 64'(bus.busy), 64'd0);
      chk("ignored_start_hi", 64'(bus.hi), 64'h0000_0000_4000_0001);
      chk("ignored_start_lo", 64'(bus.lo), 64'h0000_0000_8000_0000);
      step();

      // reset during a divide at cycle 12
      issue(2'b10, 32'd100, 32'd7);
      repeat (11) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.read_req = 1'b1;
      @(negedge clk);
      chk("rst_mid_busy", 64'(bus.busy), 64'd0);
      chk("rst_mid_hi", 64'(bus.hi), 64'd0);
      chk("rst_mid_lo", 64'(bus.lo), 64'd0);
      chk("rst_mid_stall", 64'(bus.stall), 64'd0);
      step();
      bus.read_req = 1'b0;
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) ndone++;
         @(posedge clk); #1;
      end
      chk("rst_mid_no_done", 64'(ndone), 64'd0);
      run_check("div_100_7", 2'b10, 32'd100, 32'd7, 35, 32'd2, 32'd14, 1'b0);

      // IDLE HI/LO writes
      bus.mthi = 1'b1; bus.mt_data = 32'h0000_1234;
      step();
      bus.mthi = 1'b0;
      chk("mthi_hi", 64'(bus.hi), 64'h0000_0000_0000_1234);
      chk("mthi_lo", 64'(bus.lo), 64'd14);
      bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.mt_data = 32'hA5A5_A5A5;
      step();
      bus.mthi = 1'b0; bus.mtlo = 1'b0;
      chk("mthilo_hi", 64'(bus.hi), 64'h0000_0000_A5A5_A5A5);
      chk("mthilo_lo", 64'(bus.lo), 64'h0000_0000_A5A5_A5A5);
      step();
      bus.mtlo = 1'b1; bus.mt_data = 32'hDEAD_BEEF;
      issue(2'b01, 32'd1, 32'd1);
      chk("start_mtlo_lo", 64'(bus.lo), 64'h0000_0000_A5A5_A5A5);
      wait_done(cyc, nb, dz);
      chk("start_mtlo_res_hi", 64'(bus.hi), 64'd0);
      chk("start_mtlo_res_lo", 64'(bus.lo), 64'd1);
      step();
      repeat (2) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative multiply/divide unit and HI/LO controller for the 5-stage MIPS core. Decode issues MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO to it. It sequences a shift-add multiplier and a restoring divider over many cycles. It owns the HI/LO registers and raises stall back to decode while a later HI/LO access or a new op would conflict.

Parameters:
MUL_BITS_PER_CYCLE, 1, multiplier bits retired per RUN cycle; legal values 1, 2, 4; multiply RUN length = 32/MUL_BITS_PER_CYCLE.
DIV_CYCLES, 32, divider RUN length; fixed at 1 quotient bit per cycle and must equal 32.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
start  in  1  decode presents a mult/div op this cycle
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_data  in  32  forwarded rs operand (multiplicand / dividend)
rt_data  in  32  forwarded rt operand (multiplier / divisor)
mthi  in  1  write mt_data to HI
mtlo  in  1  write mt_data to LO
mt_data  in  32  MTHI/MTLO data (rs)
read_req  in  1  decode holds MFHI/MFLO
busy  out  1  operation in flight
stall  out  1  hold decode and upstream stages
hi  out  32  HI register
lo  out  32  LO register
done  out  1  one-cycle pulse; new HI/LO are valid this cycle
div_by_zero  out  1  pulses with done when the divisor was 0

Behaviour:
- Reset (rst=1 at edge): state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0. Applies mid-operation too: the operation is abandoned, HI/LO are not written and done is not pulsed.
- States and transitions:
  - IDLE -> PREP on start.
  - PREP (1 cycle) -> RUN.
  - RUN (N cycles) -> FIX.
  - FIX (1 cycle) -> IDLE.
- PREP: operands are captured at the start edge and later port changes are ignored. PREP takes absolute values for signed ops and records the result signs.
- RUN, multiply: 64-bit accumulator adds the left-shifting multiplicand for each set multiplier bit; the multiplier shifts right.
- RUN, divide: restoring 1 bit/cycle on the 32-bit magnitudes.
- FIX: applies signs, then writes HI/LO at the FIX edge.
  - Signed product is negated when the operand signs differ.
  - Quotient is negated when the signs differ; remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (natural wrap).
- Divide by zero (rt=0, DIV or DIVU): lo=0xFFFFFFFF, hi=rs_data as captured; div_by_zero=1 with done. Takes the same latency as a normal divide.
- Latency, start edge = cycle 0: PREP in cycle 1, RUN in cycles 2..N+1, FIX in cycle N+2; done and new HI/LO are visible in cycle N+3.
  - Multiply with MUL_BITS_PER_CYCLE=1: cycle 35.
  - Divide: cycle 35.
- busy = (state != IDLE); it is high from cycle 1 through FIX.
- stall = busy & (start | read_req | mthi | mtlo), combinational.
  - In the done cycle busy=0, so MFHI reads the new value with no stall.
  - A start during busy is ignored; decode re-presents it.
- IDLE accesses:
  - mthi/mtlo write HI/LO at the next edge.
  - start together with mthi/mtlo: start wins and the mt write is dropped (not a legal single instruction).
  - mthi and mtlo together write both registers.
- MFHI/MFLO read hi/lo directly; decode selects which one.
- done and div_by_zero are registered and high for exactly one cycle.

Optional Feature:
MULDIV_EARLY_OUT_EN:
- Defined: a multiply RUN ends as soon as the remaining multiplier bits are all zero, going straight to FIX. A RUN is still at least 1 cycle. The result is exact because the multiplicand is left-shifted into a full-width accumulator.
  - Example with MUL_BITS_PER_CYCLE=1: MULTU 9*5 uses 3 RUN cycles, so done comes at cycle 6.
  - Divide is unaffected.
- Undefined: fixed latency of N=32/MUL_BITS_PER_CYCLE RUN cycles for every multiply.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF, MUL_BITS_PER_CYCLE=1, macro off -> done at cycle 35, hi=0xFFFFFFFE, lo=0x00000001, busy=1 in cycles 1-34.
- MULT 0xFFFFFFFD(-3) * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Repeat with MUL_BITS_PER_CYCLE=4 -> same result, done at cycle 11.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> lo=0xFFFFFFFF, hi=7, div_by_zero=1 with done at cycle 35.
- Start MULTU, raise read_req at cycle 5 and hold -> stall=1 in cycles 5-34, stall=0 at cycle 35 with new lo visible. A second start at cycle 10 -> stall=1, op ignored, HI/LO reflect only the first op.
- rst at cycle 12 of a DIV -> cycle 13: busy=0, hi=lo=0, stall=0; done never pulses; the next start behaves normally.
- IDLE: mthi with mt_data=0x00001234 -> hi=0x1234 next cycle, lo unchanged. mthi+mtlo with 0xA5A5A5A5 -> both written. start+mtlo together -> lo not written.
